// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension arbiter: default widths,
// FSM state encoding and extension-mode constants.
package imm_ext_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: widens an IN_W-bit immediate to OUT_W
// bits, filling the upper bits with zeros or with copies of the sign bit.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  imm,
  input  logic             sext,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [PAD_W-1:0] w_fill;

  assign w_fill = (sext == EXT_SIGN) ? {PAD_W{imm[IN_W-1]}} : '0;
  assign ext    = {w_fill, imm};

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between NREQ requesters.
// A granted request is captured in IDLE, extended and registered in EXT, and
// presented on the response channel in RESP until the consumer accepts it.
// Optional build macro IMM_EXT_STATS_EN adds per-requester saturating
// 16-bit grant counters on output port grant_cnt.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IN_W-1:0] req_imm,
  input  logic [NREQ-1:0]      req_sext,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OUT_W-1:0]     rsp_data,
  output logic [ID_W-1:0]      rsp_id
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt
`endif
);

  // Returns {found, index} of the first valid requester at or after ptr,
  // searching cyclically. Iterating downwards lets the closest index win.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] result;
    int            idx;
    result = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx[ID_W-1:0]]) begin
        result = {1'b1, idx[ID_W-1:0]};
      end
    end
    return result;
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [IN_W-1:0]  r_cap_imm;
  logic             r_cap_sext;
  logic [ID_W-1:0]  r_cap_id;
  logic [OUT_W-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;

  logic [ID_W:0]    w_pick;
  logic             w_found;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_ptr_next;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_grant;
  logic [OUT_W-1:0] w_ext;

  assign w_pick     = rr_pick(req_valid, r_rr_ptr);
  assign w_found    = w_pick[ID_W];
  assign w_winner   = w_pick[ID_W-1:0];
  assign w_ptr_next = ID_W'((int'(w_winner) + 1) % NREQ);

  // Next-state and grant decode; only IDLE can accept a request.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant               = 1'b1;
          w_req_ready[w_winner] = 1'b1;
          w_state_next          = EXT;
        end
      end
      EXT: begin
        w_state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Ready is forced low while reset is held so no handshake is seen then.
  assign req_ready = w_req_ready & {NREQ{rst_n}};
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the winning request and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_cap_imm  <= '0;
      r_cap_sext <= EXT_ZERO;
      r_cap_id   <= '0;
    end else if (w_grant) begin
      r_rr_ptr   <= w_ptr_next;
      r_cap_imm  <= req_imm[w_winner*IN_W +: IN_W];
      r_cap_sext <= req_sext[w_winner];
      r_cap_id   <= w_winner;
    end
  end

  imm_ext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm  (r_cap_imm),
    .sext (r_cap_sext),
    .ext  (w_ext)
  );

  // Register the extended result in EXT; it then holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else if (r_state == EXT) begin
      r_rsp_data <= w_ext;
      r_rsp_id   <= r_cap_id;
    end
  end

`ifdef IMM_EXT_STATS_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] r_cnt;

      // Saturating count of accepted requests for this requester.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (req_valid[gi] && req_ready[gi] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign grant_cnt[gi*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Randomised scoreboard bench for imm_ext_arbiter with three requesters.
// A transaction-level model predicts grants and responses from the
// round-robin and extension rules; a separate monitor checks responses.
module tb_imm_ext_arbiter;

  localparam int NREQ  = 3;
  localparam int IN_W  = 8;
  localparam int OUT_W = 20;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_imm;
  logic [NREQ-1:0]      req_sext;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;
`ifdef IMM_EXT_STATS_EN
  logic [NREQ*16-1:0]   grant_cnt;
`endif

  always #5 clk = ~clk;

  imm_ext_arbiter #(
    .NREQ  (NREQ),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_imm   (req_imm),
    .req_sext  (req_sext),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef IMM_EXT_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  typedef struct {
    int data;
    int id;
  } exp_t;

  exp_t            exp_q[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              m_ptr = 0;
  bit              m_busy = 1'b0;
  int              m_grant_cyc = 0;
  bit              chk_en = 1'b0;
  logic [NREQ-1:0] granted = '0;
  int              pend[NREQ];
  bit              fixed_en[NREQ];
  int              fix_imm[NREQ];
  bit              fix_sext[NREQ];
  int              m_cnt[NREQ];
  int              p_ready = 100;
  int              n_grants = 0;
  int              n_rsp = 0;

  // Extension expressed arithmetically: a negative 8-bit value v maps to
  // 2^OUT_W + v, anything else is unchanged.
  function automatic int ext_ref(input int imm, input bit sext);
    if (sext && imm >= 128) return imm - 256 + (1 << OUT_W);
    return imm;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: predicts which requester is granted this cycle.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int              w;
    int              idx;
    exp_t            e;
    exp_ready = '0;
    w = 0;
    if (chk_en) begin
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (req_valid[idx] && exp_ready == '0) begin
            exp_ready[idx] = 1'b1;
            w = idx;
          end
        end
      end
      check("req_ready", int'(req_ready), int'(exp_ready));
      if (exp_ready != '0) begin
        e.data = ext_ref(int'(req_imm[w*IN_W +: IN_W]), req_sext[w]);
        e.id   = w;
        exp_q.push_back(e);
        m_ptr       = (w + 1) % NREQ;
        m_busy      = 1'b1;
        m_grant_cyc = cyc;
        n_grants++;
        m_cnt[w]++;
        $display("cycle %0d GRANT id=%0d imm=0x%02h sext=%0d expect=0x%05h",
                 cyc, w, req_imm[w*IN_W +: IN_W], req_sext[w], e.data);
      end
    end
    granted = exp_ready;
  end

  // Monitor: checks the response channel and retires scoreboard entries.
  always @(negedge clk) begin
    bit exp_rv;
    #1;
    if (chk_en) begin
      exp_rv = m_busy && (cyc >= m_grant_cyc + 2);
      check("rsp_valid", int'(rsp_valid), int'(exp_rv));
      if (rsp_valid && exp_rv && exp_q.size() > 0) begin
        check("rsp_data", int'(rsp_data), exp_q[0].data);
        check("rsp_id", int'(rsp_id), exp_q[0].id);
        if (rsp_ready) begin
          $display("cycle %0d RESP id=%0d data=0x%05h", cyc, rsp_id, rsp_data);
          void'(exp_q.pop_front());
          m_busy = 1'b0;
          n_rsp++;
        end
      end
    end
  end

  // One stimulus cycle: hold unaccepted requests, issue pending ones.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !granted[i]) begin
        // request still waiting: imm and sext must not change
      end else if (pend[i] > 0) begin
        pend[i]--;
        req_valid[i] = 1'b1;
        if (fixed_en[i]) begin
          req_imm[i*IN_W +: IN_W] = fix_imm[i][IN_W-1:0];
          req_sext[i]             = fix_sext[i];
        end else begin
          req_imm[i*IN_W +: IN_W] = IN_W'($urandom_range(255));
          req_sext[i]             = 1'($urandom_range(1));
        end
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = (int'($urandom_range(99)) < p_ready);
  endtask

  task automatic run(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic set_fixed(input int i, input int imm, input bit sext);
    fixed_en[i] = 1'b1;
    fix_imm[i]  = imm;
    fix_sext[i] = sext;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_data"}, int'(rsp_data), 0);
    check({tag, "_rsp_id"}, int'(rsp_id), 0);
    check({tag, "_req_ready"}, int'(req_ready), 0);
  endtask

  initial begin
    bit found;
    rst_n     = 1'b0;
    req_valid = '0;
    req_imm   = '0;
    req_sext  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]     = 0;
      fixed_en[i] = 1'b0;
      fix_imm[i]  = 0;
      fix_sext[i] = 1'b0;
      m_cnt[i]    = 0;
    end

    // Reset state, with requests pending so ready gating is exercised.
    repeat (3) @(posedge clk);
    req_valid = '1;
    @(negedge clk);
    check_idle_outputs("reset");
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single requests: zero extension, then sign vs zero of the same value.
    set_fixed(0, 8'h17, 1'b0); pend[0] = 1; run(8);
    set_fixed(1, 8'hD8, 1'b1); pend[1] = 1; run(8);
    set_fixed(1, 8'hD8, 1'b0); pend[1] = 1; run(8);

    // Contention between requesters 0 and 1: grants must alternate.
    set_fixed(0, 8'h54, 1'b0);
    set_fixed(1, 8'hAF, 1'b1);
    pend[0] = 2;
    pend[1] = 2;
    run(20);

    // Backpressure: response stalls in RESP, then releases.
    set_fixed(2, 8'h80, 1'b1);
    pend[2] = 1;
    pend[0] = 1;
    p_ready = 0;
    run(10);
    p_ready = 100;
    run(10);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < NREQ; i++) fixed_en[i] = 1'b0;
    p_ready = 70;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] == 0 && $urandom_range(3) == 0) pend[i] = 1 + int'($urandom_range(2));
      end
      drive_cycle();
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    p_ready = 100;
    run(30);
    check("drain_queue", exp_q.size(), 0);
    check("rsp_count", n_rsp, n_grants);

    // Reset while the extender is busy: response dropped, pointer restarts.
    for (int i = 0; i < NREQ; i++) pend[i] = 50;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      drive_cycle();
      @(negedge clk);
      #2;
      if (m_busy && cyc == m_grant_cyc + 1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL ext_state_wait: got no EXT cycle, required one within 40 cycles");
    end else begin
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_idle_outputs("midreset");
      exp_q.delete();
      m_busy = 1'b0;
      m_ptr  = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      n_grants = 0;
      n_rsp    = 0;
      run(2);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      run(24);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    run(30);
    check("drain_after_reset", exp_q.size(), 0);

`ifdef IMM_EXT_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      check("grant_cnt", int'(grant_cnt[i*16 +: 16]), m_cnt[i]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
